// File: rtl/imm_extend_stage_pkg.sv
// Shared definitions for the immediate-extension stage.
//   ext_mode_e : extension mode encoding (zero, sign, upper/LUI, branch)
//   IMM_W / WORD_W / REG_ADDR_W : default widths for the MIPS datapath
package imm_extend_stage_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'b00,
    EXT_SIGN   = 2'b01,
    EXT_UPPER  = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_mode_e;

  localparam int IMM_W      = 16;
  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/imm_extend_stage_if.sv
// Handshake bundle between ID, the extension stage and EX.
//   Input side : InValid, InReady, Immediate, ExtendMode, InTag
//   Output side: OutValid, OutReady, Result, OutTag
// slave  = the stage itself, master = the surrounding pipeline (ID producer + EX consumer).
interface imm_extend_stage_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) ();
  logic             InValid;
  logic             InReady;
  logic [IN_W-1:0]  Immediate;
  logic [1:0]       ExtendMode;
  logic [TAG_W-1:0] InTag;
  logic             OutValid;
  logic             OutReady;
  logic [OUT_W-1:0] Result;
  logic [TAG_W-1:0] OutTag;

  modport slave (
    input  InValid, Immediate, ExtendMode, InTag, OutReady,
    output InReady, OutValid, Result, OutTag
  );

  modport master (
    output InValid, Immediate, ExtendMode, InTag, OutReady,
    input  InReady, OutValid, Result, OutTag
  );
endinterface

// File: rtl/imm_extend_core.sv
// Combinational immediate extender.
//   imm  : IN_W-bit raw immediate
//   mode : 00 zero, 01 sign, 10 upper (imm placed in the top bits), 11 branch
//   ext  : OUT_W-bit extended word
// Build option IMM_EXTEND_BRANCH_SHIFT_EN: when defined, mode 11 yields the
// sign-extended immediate shifted left by 2 (top two bits dropped); when
// undefined, mode 11 is identical to sign mode.
// With OUT_W == IN_W every mode passes the immediate unchanged.
module imm_extend_core
  import imm_extend_stage_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);
  localparam int SH = OUT_W - IN_W;

  logic [OUT_W-1:0] zext, sext, upper, branch;

  assign zext  = OUT_W'(imm);
  assign sext  = OUT_W'($signed(imm));
  assign upper = zext << SH;

`ifdef IMM_EXTEND_BRANCH_SHIFT_EN
  // Equal widths leave no room to extend, so the offset is passed as-is.
  assign branch = (SH == 0) ? zext : (sext << 2);
`else
  assign branch = sext;
`endif

  always_comb begin
    ext = zext;
    case (ext_mode_e'(mode))
      EXT_ZERO:   ext = zext;
      EXT_SIGN:   ext = sext;
      EXT_UPPER:  ext = upper;
      EXT_BRANCH: ext = branch;
      default:    ext = zext;
    endcase
  end
endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage between ID and EX.
//   CLK, Reset_n : rising-edge clock, synchronous active-low reset
//   Flush        : squash every buffered item (and any input offered this cycle)
//   bus (slave)  : valid/ready input side (Immediate/ExtendMode/InTag) and
//                  valid/ready output side (Result/OutTag)
//   Count        : number of buffered items, 0..2
// Extension happens on the way in; the extended word is stored. A 2-entry
// skid buffer (head + skid register) keeps InReady a pure function of the
// registered occupancy, so EX back-pressure never reaches ID combinationally.
// Build option IMM_EXTEND_BRANCH_SHIFT_EN selects the branch-offset mode (see imm_extend_core).
module imm_extend_stage
  import imm_extend_stage_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W,
  parameter int TAG_W = REG_ADDR_W
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic                Flush,
  imm_extend_stage_if.slave   bus,
  output logic [1:0]          Count
);
  logic [OUT_W-1:0] ext;

  imm_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm  (bus.Immediate),
    .mode (bus.ExtendMode),
    .ext  (ext)
  );

  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_W-1:0] head_res_q, head_res_d, skid_res_q, skid_res_d;
  logic [TAG_W-1:0] head_tag_q, head_tag_d, skid_tag_q, skid_tag_d;
  logic             push, pop;

  assign push = bus.InValid & in_ready_q;
  assign pop  = (count_q != 2'd0) & bus.OutReady;

  always_comb begin
    count_d    = count_q;
    head_res_d = head_res_q;
    head_tag_d = head_tag_q;
    skid_res_d = skid_res_q;
    skid_tag_d = skid_tag_q;
    // Flush leaves the data registers alone so an empty stage still shows
    // the last item it presented.
    if (Flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: if (push) begin
          head_res_d = ext;
          head_tag_d = bus.InTag;
          count_d    = 2'd1;
        end
        2'd1: begin
          if (push && pop) begin
            head_res_d = ext;
            head_tag_d = bus.InTag;
          end else if (push) begin
            skid_res_d = ext;
            skid_tag_d = bus.InTag;
            count_d    = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: if (pop) begin
          // push cannot occur here: InReady is low when full
          head_res_d = skid_res_q;
          head_tag_d = skid_tag_q;
          count_d    = 2'd1;
        end
        default: count_d = 2'd0;
      endcase
    end
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      head_res_q <= '0;
      head_tag_q <= '0;
      skid_res_q <= '0;
      skid_tag_q <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      head_res_q <= head_res_d;
      head_tag_q <= head_tag_d;
      skid_res_q <= skid_res_d;
      skid_tag_q <= skid_tag_d;
    end
  end

  assign bus.InReady  = in_ready_q;
  assign bus.OutValid = (count_q != 2'd0);
  assign bus.Result   = head_res_q;
  assign bus.OutTag   = head_tag_q;
  assign Count        = count_q;
endmodule

// File: tb/tb_imm_extend_stage.sv
// Scoreboard bench: a 16->32 stage and an 8->8 stage are driven with the same
// handshake stimulus; the driver queues expected items on acceptance and a
// negedge monitor checks occupancy, handshake outputs and head data.
module tb_imm_extend_stage;

  logic CLK = 1'b0;
  logic Reset_n, Flush;
  logic [1:0] cnt32, cnt8;

  always #5 CLK = ~CLK;

  imm_extend_stage_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus32 ();
  imm_extend_stage_if #(.IN_W(8),  .OUT_W(8),  .TAG_W(5)) bus8 ();

  imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut32 (
    .CLK(CLK), .Reset_n(Reset_n), .Flush(Flush), .bus(bus32), .Count(cnt32)
  );
  imm_extend_stage #(.IN_W(8), .OUT_W(8), .TAG_W(5)) dut8 (
    .CLK(CLK), .Reset_n(Reset_n), .Flush(Flush), .bus(bus8), .Count(cnt8)
  );

  typedef struct {
    logic [31:0] r32;
    logic [7:0]  r8;
    logic [4:0]  tag;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: extension computed with plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input int in_w, input int out_w,
                                          input logic [15:0] imm, input logic [1:0] mode);
    longint unsigned full, v, sv, res;
    full = 64'd1 << out_w;
    v    = longint'(imm) & ((64'd1 << in_w) - 1);
    sv   = (v >= (64'd1 << (in_w - 1))) ? v + full - (64'd1 << in_w) : v;
    case (mode)
      2'd0: res = v;
      2'd1: res = sv;
      2'd2: res = (v * (64'd1 << (out_w - in_w))) % full;
`ifdef IMM_EXTEND_BRANCH_SHIFT_EN
      default: res = (in_w == out_w) ? v : (sv * 4) % full;
`else
      default: res = sv;
`endif
    endcase
    return res[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, record the expected item if it will be accepted.
  task automatic step(input logic rst_n, input logic v, input logic fl, input logic ordy,
                      input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    item_t it;
    Reset_n          = rst_n;
    Flush            = fl;
    bus32.InValid    = v;
    bus32.Immediate  = imm;
    bus32.ExtendMode = mode;
    bus32.InTag      = tag;
    bus32.OutReady   = ordy;
    bus8.InValid     = v;
    bus8.Immediate   = imm[7:0];
    bus8.ExtendMode  = mode;
    bus8.InTag       = tag;
    bus8.OutReady    = ordy;
    if (rst_n && !fl && v && bus32.InReady === 1'b1) begin
      it.r32 = ref_ext(16, 32, imm, mode);
      it.r8  = 8'(ref_ext(8, 8, {8'h00, imm[7:0]}, mode));
      it.tag = tag;
      exp_q.push_back(it);
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: occupancy model plus scoreboard head comparison.
  int          mcount = 0;
  logic        armed = 1'b0;
  logic [31:0] last32 = '0;
  logic [7:0]  last8 = '0;
  logic [4:0]  last_tag = '0;

  always @(negedge CLK) begin
    logic in_x, out_x;
    if (armed) begin
      chk("count32", 64'(cnt32), 64'(mcount));
      chk("count8", 64'(cnt8), 64'(mcount));
      chk("in_ready", 64'(bus32.InReady), 64'(mcount != 2));
      chk("out_valid", 64'(bus32.OutValid), 64'(mcount != 0));
      chk("out_valid8", 64'(bus8.OutValid), 64'(mcount != 0));
      if (mcount != 0) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
          chk("result32", 64'(bus32.Result), 64'(exp_q[0].r32));
          chk("result8", 64'(bus8.Result), 64'(exp_q[0].r8));
          chk("out_tag", 64'(bus32.OutTag), 64'(exp_q[0].tag));
          last32   = exp_q[0].r32;
          last8    = exp_q[0].r8;
          last_tag = exp_q[0].tag;
        end
      end else begin
        chk("hold_result32", 64'(bus32.Result), 64'(last32));
        chk("hold_result8", 64'(bus8.Result), 64'(last8));
        chk("hold_tag", 64'(bus32.OutTag), 64'(last_tag));
      end
    end
    // Advance the model to what the coming edge should produce.
    if (Reset_n !== 1'b1) begin
      exp_q.delete();
      mcount   = 0;
      last32   = '0;
      last8    = '0;
      last_tag = '0;
      armed    = 1'b1;
    end else if (armed) begin
      in_x  = bus32.InValid && (mcount != 2);
      out_x = (mcount != 0) && bus32.OutReady;
      if (out_x && exp_q.size() > 0) void'(exp_q.pop_front());
      if (Flush) begin
        exp_q.delete();
        mcount = 0;
      end else begin
        mcount = mcount + int'(in_x) - int'(out_x);
      end
    end
  end

  initial begin
    logic [15:0] imm;
    // Reset with a valid input pending: nothing may be captured.
    step(0, 1, 0, 1, 16'h1111, 2'd1, 5'd9);
    step(0, 1, 0, 1, 16'h2222, 2'd1, 5'd9);
    // Modes with the consumer always ready.
    step(1, 1, 0, 1, 16'h8001, 2'd1, 5'd1);
    step(1, 1, 0, 1, 16'hFFFF, 2'd0, 5'd2);
    step(1, 1, 0, 1, 16'h1234, 2'd2, 5'd3);
    step(1, 1, 0, 1, 16'hFFFC, 2'd3, 5'd4);
    step(1, 1, 0, 1, 16'h0080, 2'd1, 5'd5);
    step(1, 1, 0, 1, 16'h007F, 2'd3, 5'd6);
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    // Back-pressure: fill with tags 3 and 7, then one more offer that must stall.
    step(1, 1, 0, 0, 16'hA5A5, 2'd1, 5'd3);
    step(1, 1, 0, 0, 16'h5A5A, 2'd2, 5'd7);
    step(1, 1, 0, 0, 16'h0F0F, 2'd0, 5'd11);
    step(1, 0, 0, 0, 16'h0000, 2'd0, 5'd0);
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    // Simultaneous in/out at Count=1.
    step(1, 1, 0, 0, 16'h1000, 2'd0, 5'd12);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 16'h9000 + 16'(i), 2'(i), 5'(13 + i));
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    // Flush at Count=2 with an input offered: everything dropped.
    step(1, 1, 0, 0, 16'h4444, 2'd1, 5'd20);
    step(1, 1, 0, 0, 16'h5555, 2'd1, 5'd21);
    step(1, 1, 1, 0, 16'h6666, 2'd1, 5'd22);
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    step(1, 1, 0, 1, 16'h7777, 2'd1, 5'd23);
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    // Reset mid-stream.
    step(1, 1, 0, 0, 16'h8888, 2'd1, 5'd24);
    step(1, 1, 0, 0, 16'h9999, 2'd1, 5'd25);
    step(0, 1, 0, 1, 16'hAAAA, 2'd1, 5'd26);
    step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: imm = 16'h8000;
        1: imm = 16'h7FFF;
        2: imm = 16'hFFFF;
        3: imm = 16'h0080;
        default: imm = 16'($urandom);
      endcase
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
           imm, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 16'h0000, 2'd0, 5'd0);
    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
